data_bus: RTL and testbench

DATA_BUS -- requirements
Module: data_bus

---
 rtl/data_bus_pkg.sv | 21 ++
 rtl/uart_tx.sv | 102 ++++++++++
 rtl/data_bus.sv | 126 ++++++++++++
 tb/tb_data_bus.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_bus_pkg.sv
// Shared constants and types for the data bus slice: memory map,
// status bit positions and UART serializer states.
package data_bus_pkg;

  localparam logic [31:0] ADDR_RAM_BASE    = 32'h0000_0000;
  localparam logic [31:0] ADDR_UART_DATA   = 32'h8000_0000;
  localparam logic [31:0] ADDR_UART_STATUS = 32'h8000_0004;
  localparam logic [31:0] ADDR_TIMER       = 32'h8000_0008;

  localparam int STAT_FULL  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_BUSY  = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } uart_state_e;

endpackage

// File: rtl/uart_tx.sv
// UART serializer: 8N1 framing with baud and bit counters.
// tx_ready marks the cycle a new byte may be taken (IDLE or end of STOP).
module uart_tx
  import data_bus_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_byte,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_line,
  output logic       tx_busy
);

  localparam int BW = $clog2(CLKS_PER_BIT);

  uart_state_e   state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          baud_last;

  assign baud_last = (baud_q == BW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    tx_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_ready = 1'b1;
        if (tx_valid) begin
          state_d = ST_START;
          baud_d  = '0;
          shreg_d = tx_byte;
        end
      end
      ST_START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (baud_last) begin
          baud_d  = '0;
          shreg_d = shreg_q >> 1;
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = ST_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (baud_last) begin
          baud_d   = '0;
          tx_ready = 1'b1;
          // chain straight into the next start bit when data is waiting
          if (tx_valid) begin
            state_d = ST_START;
            shreg_d = tx_byte;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign tx_busy = (state_q != ST_IDLE);
  assign tx_line = (state_q == ST_START) ? 1'b0 :
                   (state_q == ST_DATA)  ? shreg_q[0] : 1'b1;

endmodule

// File: rtl/data_bus.sv
// CPU data bus: RAM, UART tx FIFO + status, optional cycle timer.
// Timer is built only when DATA_BUS_TIMER_EN is defined.
module data_bus
  import data_bus_pkg::*;
#(
  parameter int RAM_WORDS    = 1024,
  parameter int FIFO_DEPTH   = 4,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wr,
  input  logic [3:0]  data_wr_en,
  output logic [31:0] data_rd,
  output logic        uart_tx
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);

  logic [31:0] word_addr;
  logic        ram_sel, udata_sel, status_sel, timer_sel;
  logic [AW-1:0] ram_idx;
  logic        unused_addr;

  assign word_addr   = {data_addr[31:2], 2'b00};
  assign unused_addr = ^data_addr[1:0];
  assign ram_sel     = (data_addr[31:AW+2] == ADDR_RAM_BASE[31:AW+2]);
  assign ram_idx     = data_addr[AW+1:2];
  assign udata_sel   = (word_addr == ADDR_UART_DATA);
  assign status_sel  = (word_addr == ADDR_UART_STATUS);

  logic [31:0] mem [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (rst_n && ram_sel) begin
      for (int i = 0; i < 4; i++) begin
        if (data_wr_en[i]) mem[ram_idx][8*i +: 8] <= data_wr[8*i +: 8];
      end
    end
  end

  logic [7:0]  fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count_q;
  logic        full, empty, push, pop;
  logic        tx_ready, tx_busy;

  assign full  = (count_q == (PW+1)'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign pop   = tx_ready && !empty;
  // a full FIFO still takes a byte when a slot frees in the same cycle
  assign push  = rst_n && udata_sel && data_wr_en[0] && (!full || pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= data_wr[7:0];
  end

  uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_byte (fifo_mem[rd_ptr]),
    .tx_valid(!empty),
    .tx_ready(tx_ready),
    .tx_line (uart_tx),
    .tx_busy (tx_busy)
  );

  logic [31:0] timer_val;

`ifdef DATA_BUS_TIMER_EN
  logic [31:0] timer_q;

  always_ff @(posedge clk) begin
    if (!rst_n) timer_q <= '0;
    else        timer_q <= timer_q + 32'd1;
  end

  assign timer_sel = (word_addr == ADDR_TIMER);
  assign timer_val = timer_q;
`else
  assign timer_sel = 1'b0;
  assign timer_val = '0;
`endif

  logic [31:0] status, rd_d;

  always_comb begin
    status             = '0;
    status[STAT_FULL]  = full;
    status[STAT_EMPTY] = empty;
    status[STAT_BUSY]  = tx_busy;
  end

  always_comb begin
    rd_d = '0;
    unique case (1'b1)
      ram_sel:    rd_d = mem[ram_idx];
      status_sel: rd_d = status;
      timer_sel:  rd_d = timer_val;
      default:    rd_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) data_rd <= '0;
    else        data_rd <= rd_d;
  end

endmodule

// File: tb/tb_data_bus.sv
// Directed self-checking bench for data_bus (default parameters).
// Timer expectations follow DATA_BUS_TIMER_EN.
module tb_data_bus;

  localparam logic [31:0] A_UDATA  = 32'h8000_0000;
  localparam logic [31:0] A_STATUS = 32'h8000_0004;
  localparam logic [31:0] A_TIMER  = 32'h8000_0008;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] data_addr;
  logic [31:0] data_wr;
  logic [3:0]  data_wr_en;
  logic [31:0] data_rd;
  logic        uart_tx;

  int checks = 0;
  int errors = 0;

  data_bus dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_addr (data_addr),
    .data_wr   (data_wr),
    .data_wr_en(data_wr_en),
    .data_rd   (data_rd),
    .uart_tx   (uart_tx)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] e);
    data_addr  = a;
    data_wr    = d;
    data_wr_en = e;
    step();
    data_addr  = '0;
    data_wr    = '0;
    data_wr_en = '0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] v);
    data_addr  = a;
    data_wr_en = '0;
    step();
    v = data_rd;
    data_addr = '0;
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int p);
    int idx;
    idx = p / 16;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    return 1'b1;
  endfunction

  task automatic test_reset();
    rst_n      = 1'b0;
    data_addr  = '0;
    data_wr    = '0;
    data_wr_en = '0;
    step();
    step();
    checks++;
    if (data_rd !== 32'h0) begin
      errors++;
      $display("FAIL reset_rd got %h want 0", data_rd);
    end
    checks++;
    if (uart_tx !== 1'b1) begin
      errors++;
      $display("FAIL reset_tx got %b want 1", uart_tx);
    end
    rst_n = 1'b1;
    begin
      logic [31:0] v;
      do_read(A_STATUS, v);
      checks++;
      if (v !== 32'h2) begin
        errors++;
        $display("FAIL reset_status got %h want 2", v);
      end
    end
  endtask

  task automatic test_ram();
    logic [31:0] v;
    do_write(32'h10, 32'hDEADBEEF, 4'b1111);
    do_read(32'h10, v);
    checks++;
    if (v !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL ram_full got %h want deadbeef", v);
    end
    do_write(32'h10, 32'h0000AA00, 4'b0010);
    do_read(32'h13, v);
    checks++;
    if (v !== 32'hDEADAAEF) begin
      errors++;
      $display("FAIL ram_lane got %h want deadaaef", v);
    end
    do_write(32'h20, 32'h11111111, 4'b1111);
    do_write(32'h20, 32'h22222222, 4'b1111);
    begin
      data_addr  = 32'h20;
      data_wr    = 32'h33333333;
      data_wr_en = 4'b1111;
      step();
      v = data_rd;
      data_wr_en = '0;
      data_addr  = '0;
    end
    checks++;
    if (v !== 32'h22222222) begin
      errors++;
      $display("FAIL ram_read_first got %h want 22222222", v);
    end
    do_read(32'h20, v);
    checks++;
    if (v !== 32'h33333333) begin
      errors++;
      $display("FAIL ram_after_rf got %h want 33333333", v);
    end
    do_write(32'hFFC, 32'hCAFEF00D, 4'b1111);
    do_write(32'h0, 32'h01020304, 4'b1111);
    do_write(32'h1000, 32'hBAADBAAD, 4'b1111);
    do_read(32'hFFC, v);
    checks++;
    if (v !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL ram_top got %h want cafef00d", v);
    end
    do_read(32'h0, v);
    checks++;
    if (v !== 32'h01020304) begin
      errors++;
      $display("FAIL ram_no_alias got %h want 01020304", v);
    end
    do_read(32'h1000, v);
    checks++;
    if (v !== 32'h0) begin
      errors++;
      $display("FAIL unmapped_1000 got %h want 0", v);
    end
  endtask

  task automatic test_uart_frame();
    int bad_line;
    int bad_busy;
    logic exp;
    bad_line = 0;
    bad_busy = 0;
    do_write(A_UDATA, 32'h0000_0055, 4'b0001);
    data_addr = A_STATUS;
    for (int k = 1; k <= 162; k++) begin
      step();
      exp = (k <= 160) ? frame_bit(8'h55, k - 1) : 1'b1;
      if (uart_tx !== exp) bad_line++;
      if (k >= 2 && k <= 161 && data_rd[2] !== 1'b1) bad_busy++;
    end
    checks++;
    if (bad_line !== 0) begin
      errors++;
      $display("FAIL frame_55_line got %0d bad cycles want 0", bad_line);
    end
    checks++;
    if (bad_busy !== 0) begin
      errors++;
      $display("FAIL frame_55_busy got %0d bad cycles want 0", bad_busy);
    end
    checks++;
    if (data_rd !== 32'h2) begin
      errors++;
      $display("FAIL frame_55_idle got %h want 2", data_rd);
    end
    data_addr = '0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] b [6];
    int bad [5];
    int bad_tail;
    logic exp;
    b = '{8'h01, 8'hA5, 8'h3C, 8'hF0, 8'h81, 8'h7E};
    foreach (bad[j]) bad[j] = 0;
    bad_tail = 0;
    for (int k = 0; k <= 805; k++) begin
      if (k < 6) begin
        data_addr  = A_UDATA;
        data_wr    = {24'h0, b[k]};
        data_wr_en = 4'b0001;
      end else begin
        data_addr  = A_STATUS;
        data_wr    = '0;
        data_wr_en = '0;
      end
      step();
      if (k >= 1 && k <= 800) begin
        exp = frame_bit(b[(k-1)/160], (k-1) % 160);
        if (uart_tx !== exp) bad[(k-1)/160]++;
      end else if (k > 800 && uart_tx !== 1'b1) begin
        bad_tail++;
      end
      if (k == 6 || k == 7) begin
        checks++;
        if (data_rd !== 32'h5) begin
          errors++;
          $display("FAIL b2b_full k=%0d got %h want 5", k, data_rd);
        end
      end
      if (k == 700) begin
        checks++;
        if (data_rd !== 32'h6) begin
          errors++;
          $display("FAIL b2b_drain got %h want 6", data_rd);
        end
      end
      if (k == 805) begin
        checks++;
        if (data_rd !== 32'h2) begin
          errors++;
          $display("FAIL b2b_idle got %h want 2", data_rd);
        end
      end
    end
    for (int j = 0; j < 5; j++) begin
      checks++;
      if (bad[j] !== 0) begin
        errors++;
        $display("FAIL b2b_frame%0d got %0d bad cycles want 0", j, bad[j]);
      end
    end
    checks++;
    if (bad_tail !== 0) begin
      errors++;
      $display("FAIL b2b_dropped got %0d low cycles want 0", bad_tail);
    end
    data_addr = '0;
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] v;
    int bad_quiet;
    bad_quiet = 0;
    for (int k = 0; k <= 70; k++) begin
      if (k < 2) begin
        data_addr  = A_UDATA;
        data_wr    = (k == 0) ? 32'h55 : 32'h33;
        data_wr_en = 4'b0001;
      end else begin
        data_addr  = '0;
        data_wr    = '0;
        data_wr_en = '0;
      end
      step();
    end
    checks++;
    if (uart_tx !== 1'b0) begin
      errors++;
      $display("FAIL mid_bit3 got %b want 0", uart_tx);
    end
    rst_n      = 1'b0;
    data_addr  = 32'h10;
    data_wr    = 32'h12345678;
    data_wr_en = 4'b1111;
    step();
    checks++;
    if (uart_tx !== 1'b1) begin
      errors++;
      $display("FAIL mid_abort_tx got %b want 1", uart_tx);
    end
    checks++;
    if (data_rd !== 32'h0) begin
      errors++;
      $display("FAIL mid_abort_rd got %h want 0", data_rd);
    end
    rst_n      = 1'b1;
    data_wr    = '0;
    data_wr_en = '0;
    do_read(A_STATUS, v);
    checks++;
    if (v !== 32'h2) begin
      errors++;
      $display("FAIL mid_status got %h want 2", v);
    end
    for (int k = 0; k < 200; k++) begin
      step();
      if (uart_tx !== 1'b1) bad_quiet++;
    end
    checks++;
    if (bad_quiet !== 0) begin
      errors++;
      $display("FAIL mid_discard got %0d low cycles want 0", bad_quiet);
    end
    do_read(32'h10, v);
    checks++;
    if (v !== 32'hDEADAAEF) begin
      errors++;
      $display("FAIL mid_ram got %h want deadaaef", v);
    end
  endtask

  task automatic test_timer_unmapped();
    logic [31:0] t1, t2, v;
    do_read(A_TIMER, t1);
    for (int k = 0; k < 9; k++) step();
    do_read(A_TIMER, t2);
`ifdef DATA_BUS_TIMER_EN
    checks++;
    if (t2 - t1 !== 32'd10) begin
      errors++;
      $display("FAIL timer_delta got %0d want 10", t2 - t1);
    end
`else
    checks++;
    if (t1 !== 32'h0 || t2 !== 32'h0) begin
      errors++;
      $display("FAIL timer_off got %h,%h want 0,0", t1, t2);
    end
`endif
    do_read(32'h4000_0000, v);
    checks++;
    if (v !== 32'h0) begin
      errors++;
      $display("FAIL unmapped_4000 got %h want 0", v);
    end
    do_read(32'h8000_000C, v);
    checks++;
    if (v !== 32'h0) begin
      errors++;
      $display("FAIL unmapped_800c got %h want 0", v);
    end
    do_write(A_UDATA, 32'h0000_AA00, 4'b0010);
    step();
    do_read(A_STATUS, v);
    checks++;
    if (v !== 32'h2) begin
      errors++;
      $display("FAIL udata_lane1 got %h want 2", v);
    end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_uart_frame();
    test_back_to_back();
    test_reset_mid_frame();
    test_timer_unmapped();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
